store_checker: RTL

Parametrised, synthesizable store-stream checker for the pipelined MIPS core's data-memory write port. It is the successor to the single-store pass/fail bench check and monitors `memwrite`/`dataadr`/`writedata` from `top`. Each observed store is compared in order against a preloaded queue of up to DEPTH expected stores, with size-masked data compare, an optional strict address mode and a timeout. It reports a sticky pass/fail verdict with a failure code, so directed instruction tests (lbu, lhu, sb, sh, sw, …) need no hand-written bench checks.

---
 rtl/store_checker.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/store_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | store_checker : in-order checker of data-memory stores against a queue      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module store_checker #(
  parameter int DEPTH   = 8,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1000,
  parameter int STRICT  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [AW-1:0]                load_addr,
  input  logic [DW-1:0]                load_data,
  input  logic [1:0]                   load_size,
  input  logic                         start,
  input  logic [1:0]                   memwrite,
  input  logic [AW-1:0]                dataadr,
  input  logic [DW-1:0]                writedata,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [1:0]                   fail_code,
  output logic [$clog2(DEPTH+1)-1:0]   matched
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
  localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

  localparam logic [1:0] c_code_none = 2'b00;
  localparam logic [1:0] c_code_data = 2'b01;
  localparam logic [1:0] c_code_addr = 2'b10;
  localparam logic [1:0] c_code_tmo  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_PASS  = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [AW-1:0] r_q_addr [DEPTH];
  logic [DW-1:0] r_q_data [DEPTH];
  logic [1:0]    r_q_size [DEPTH];

  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_matched;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_pass, r_fail;
  logic [1:0]    r_fail_code, w_code_nxt;

  logic          w_push, w_pop;
  logic          w_addr_hit, w_data_hit;
  logic [DW-1:0] w_mask;

  function automatic logic [DW-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b01:   size_mask = DW'(8'hFF);
      2'b10:   size_mask = DW'(16'hFFFF);
      2'b11:   size_mask = '1;
      default: size_mask = '0;
    endcase
  endfunction

  assign load_ready = (r_state == S_IDLE) && (r_count != c_depth);
  assign done       = r_pass | r_fail;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign fail_code  = r_fail_code;
  assign matched    = r_matched;

  // Only the head entry is ever compared; the mask follows the expected size.
  assign w_mask     = size_mask(r_q_size[r_head]);
  assign w_addr_hit = (dataadr == r_q_addr[r_head]);
  assign w_data_hit = (memwrite == r_q_size[r_head]) &&
                      ((writedata & w_mask) == (r_q_data[r_head] & w_mask));

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_code_nxt  = r_fail_code;
    w_timer_nxt = r_timer;
    case (r_state)
      S_IDLE: begin
        w_push = load_valid && load_ready;
        if (start) begin
          w_timer_nxt = '0;
          w_state_nxt = ((r_count != '0) || w_push) ? S_ARMED : S_PASS;
        end
      end
      S_ARMED: begin
        w_timer_nxt = r_timer + TW'(1);
        // A store that decides the verdict outranks the timeout in the same cycle.
        if ((memwrite != 2'b00) && w_addr_hit) begin
          if (w_data_hit) begin
            w_pop = 1'b1;
            if (r_count == CW'(1)) w_state_nxt = S_PASS;
          end else begin
            w_state_nxt = S_FAIL;
            w_code_nxt  = c_code_data;
          end
        end else if ((memwrite != 2'b00) && (STRICT != 0)) begin
          w_state_nxt = S_FAIL;
          w_code_nxt  = c_code_addr;
        end else if (r_timer == c_tmo_last) begin
          w_state_nxt = S_FAIL;
          w_code_nxt  = c_code_tmo;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_matched   <= '0;
      r_timer     <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_code <= c_code_none;
    end else begin
      r_timer     <= w_timer_nxt;
      r_pass      <= (w_state_nxt == S_PASS);
      r_fail      <= (w_state_nxt == S_FAIL);
      r_fail_code <= (w_state_nxt == S_FAIL) ? w_code_nxt : c_code_none;
      // Push happens only in IDLE and pop only in ARMED, so they never overlap.
      if (w_push) begin
        r_tail  <= (r_tail == c_last_ptr) ? '0 : r_tail + PW'(1);
        r_count <= r_count + CW'(1);
      end else if (w_pop) begin
        r_head  <= (r_head == c_last_ptr) ? '0 : r_head + PW'(1);
        r_count <= r_count - CW'(1);
      end
      if (w_pop && (r_matched != c_depth)) r_matched <= r_matched + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_tail] <= load_addr;
      r_q_data[r_tail] <= load_data;
      r_q_size[r_tail] <= load_size;
    end
  end

endmodule
`default_nettype wire
